// File: rtl/serial_sub5_pkg.sv
// Shared definitions for the serial subtractor.
//   SLICE     : bits processed per clock (matches the 5-bit adder slices)
//   nslice_of : number of slices needed to cover a given operand width
//   state_t   : controller state encoding (IDLE accepts work, RUN iterates)
package serial_sub5_pkg;

    localparam int SLICE = 5;

    // Ceiling divide of the operand width by the slice width.
    function automatic int nslice_of(input int width);
        return (width + SLICE - 1) / SLICE;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_sub5_slice.sv
// sub5_slice: combinational 5-bit borrow-ripple subtractor.
//   a[4:0], b[4:0] : slice minuend / subtrahend
//   b_in           : borrow into bit 0
//   d[4:0]         : a - b - b_in (mod 32)
//   b_out          : borrow out of bit 4
module sub5_slice
    import serial_sub5_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             b_in,
    output logic [SLICE-1:0] d,
    output logic             b_out
);

    // br[i] is the borrow into bit i; br[SLICE] leaves the slice.
    logic [SLICE:0] br;

    assign br[0] = b_in;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_fs
            // 1-bit full subtractor: borrow when a < b + borrow_in.
            assign d[gi]      = a[gi] ^ b[gi] ^ br[gi];
            assign br[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & br[gi]);
        end
    endgenerate

    assign b_out = br[SLICE];

endmodule

// File: rtl/serial_sub5.sv
// serial_sub5: multi-cycle WIDTH-bit subtractor computing a - b one
// 5-bit slice per clock, least significant slice first, through a single
// shared sub5_slice.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, honoured only while ready = 1
//   a, b          : operands, captured on the accepting edge
//   ready         : idle, can accept start
//   done          : one-cycle pulse when results update
//   diff          : a - b mod 2^WIDTH
//   borrow        : unsigned a < b
//   zero          : diff == 0
//   ovf           : signed two's-complement overflow of a - b
// Results hold their value between done pulses.
module serial_sub5
    import serial_sub5_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = nslice_of(WIDTH);
    localparam int PW     = NSLICE * SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t state_reg, state_next;

    logic [IDX_W-1:0]              idx_reg;
    logic [NSLICE-1:0][SLICE-1:0]  a_reg, b_reg, acc_reg;
    logic                          brw_reg;

    logic                          done_reg;
    logic [WIDTH-1:0]              diff_reg;
    logic                          borrow_reg, zero_reg, ovf_reg;

    // Operands zero-padded up to a whole number of slices. The padding
    // bits never generate a borrow, so the borrow out of the top slice
    // equals the borrow out of bit WIDTH-1.
    logic [PW-1:0] a_pad, b_pad;

    always_comb begin
        a_pad            = '0;
        b_pad            = '0;
        a_pad[WIDTH-1:0] = a;
        b_pad[WIDTH-1:0] = b;
    end

    // Current slice through the shared subtractor.
    logic [SLICE-1:0] a_sel, b_sel, d_slice;
    logic             b_out_slice;

    assign a_sel = a_reg[idx_reg];
    assign b_sel = b_reg[idx_reg];

    sub5_slice u_slice (
        .a     (a_sel),
        .b     (b_sel),
        .b_in  (brw_reg),
        .d     (d_slice),
        .b_out (b_out_slice)
    );

    // Accumulator with this cycle's slice merged in; on the last slice this
    // is the complete difference, so flags are derived from it directly.
    logic [NSLICE-1:0][SLICE-1:0] acc_full;
    logic [PW-1:0]                acc_flat, a_flat, b_flat;
    logic [WIDTH-1:0]             diff_w;

    always_comb begin
        acc_full          = acc_reg;
        acc_full[idx_reg] = d_slice;
    end

    assign acc_flat = acc_full;
    assign a_flat   = a_reg;
    assign b_flat   = b_reg;
    assign diff_w   = acc_flat[WIDTH-1:0];

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)              state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            brw_reg    <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a_pad;
                        b_reg   <= b_pad;
                        acc_reg <= '0;
                        idx_reg <= '0;
                        brw_reg <= 1'b0;
                    end
                end
                RUN: begin
                    acc_reg <= acc_full;
                    brw_reg <= b_out_slice;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg    <= '0;
                        done_reg   <= 1'b1;
                        diff_reg   <= diff_w;
                        borrow_reg <= b_out_slice;
                        zero_reg   <= (diff_w == '0);
                        ovf_reg    <= (a_flat[WIDTH-1] ^ b_flat[WIDTH-1])
                                    & (a_flat[WIDTH-1] ^ diff_w[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (state_reg == IDLE);
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;
    assign zero   = zero_reg;
    assign ovf    = ovf_reg;

endmodule
